aeris_ram_arbiter: RTL

Round-robin arbiter that shares one port of the dual-port block RAM between NREQ requesters (cores or DMA) on a single clock. Each cycle it selects at most one pending request, drives the RAM port's enable/write-enable/address/data, and returns read data to the winner one cycle later, tagged by requester. A lock input lets a requester keep the port for back-to-back bursts.

---
 rtl/aeris_ram_arbiter_pkg.sv | 15 +
 rtl/aeris_ram_arbiter_rr_pick.sv | 32 +++
 rtl/aeris_ram_arbiter.sv | 86 ++++++++
 3 files changed

// File: rtl/aeris_ram_arbiter_pkg.sv
// Shared defaults for the RAM-port arbiter: address/data widths and the
// requester-index width helper.
package aeris_ram_arbiter_pkg;

    localparam int unsigned AW_DEF   = 10;
    localparam int unsigned DW_DEF   = 32;
    localparam int unsigned NREQ_DEF = 4;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IW_DEF = idx_w(NREQ_DEF);

endpackage

// File: rtl/aeris_ram_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request scanning ptr, ptr+1, ... mod NREQ.
module aeris_ram_arbiter_rr_pick
    import aeris_ram_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            any,
    output logic [NREQ-1:0] win_oh,
    output logic [IW-1:0]   win_idx
);

    logic [IW-1:0] p;

    always_comb begin
        any     = 1'b0;
        win_oh  = '0;
        win_idx = '0;
        p       = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            p = IW'((32'(ptr) + i) % NREQ);
            if (!any && req[p]) begin
                any       = 1'b1;
                win_oh[p] = 1'b1;
                win_idx   = p;
            end
        end
    end

endmodule

// File: rtl/aeris_ram_arbiter.sv
// Round-robin arbiter sharing one block-RAM port between NREQ requesters,
// with an optional lock that keeps the port for back-to-back bursts.
module aeris_ram_arbiter
    import aeris_ram_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned DW   = DW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ-1:0]   req_lock,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rvalid,
    output logic [DW-1:0]     rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [AW-1:0]     ram_addr,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout
);

    localparam int unsigned IW = idx_w(NREQ);

    logic [IW-1:0]   ptr, owner, rd_id, pick_idx, winner;
    logic            locked, rd_pend, pick_any, hold, grant;
    logic [NREQ-1:0] pick_oh;

    aeris_ram_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .any     (pick_any),
        .win_oh  (pick_oh),
        .win_idx (pick_idx)
    );

    // The owner keeps the port only while it still requests and still asserts lock;
    // otherwise the plain round-robin scan decides this cycle.
    assign hold   = locked & req[owner] & req_lock[owner];
    assign winner = hold ? owner : pick_idx;
    assign grant  = hold | pick_any;

    always_comb begin
        gnt      = '0;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (grant) begin
            gnt      = hold ? (NREQ'(1) << owner) : pick_oh;
            ram_en   = 1'b1;
            ram_we   = req_we[winner];
            ram_addr = req_addr[winner*AW +: AW];
            ram_din  = req_wdata[winner*DW +: DW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            locked  <= 1'b0;
            owner   <= '0;
            rd_pend <= 1'b0;
            rd_id   <= '0;
        end else if (grant) begin
            ptr     <= (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);
            locked  <= req_lock[winner];
            owner   <= winner;
            rd_pend <= ~req_we[winner];
            rd_id   <= winner;
        end else begin
            rd_pend <= 1'b0;
        end
    end

    assign rvalid = rd_pend ? (NREQ'(1) << rd_id) : '0;
    assign rdata  = rd_pend ? ram_dout : '0;

endmodule
